// File: rtl/tdm_demux.sv
// ============================================================================
// tdm_demux
// ----------------------------------------------------------------------------
// Time-division demultiplexer. This is the receive end of the shared-bus
// mux datapath. Samples arrive one at a time on a shared bus. A frame-sync
// marker tags channel 0. Each sample is routed into a per-channel shadow
// register. Once a full frame has been accepted in order, the complete frame
// is presented on a flat parallel bus, together with a one-cycle valid pulse.
//
// Parameters:
//   WIDTH  sample width in bits (default 8)
//   CH     channels per frame, 2..16 (default 4)
//   SW     slot counter width, must equal ceil(log2(CH)) (default 2)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   din         sample currently on the shared bus
//   din_valid   din holds a sample this cycle
//   frame_sync  marks the current valid sample as channel 0
//   dout        last complete frame, channel k at [k*WIDTH +: WIDTH]
//   dout_valid  one-cycle pulse, dout was updated on the previous edge
//   slot        channel index the next accepted sample will fill
//   locked      high while the framer is locked to the stream
//   frame_err   one-cycle pulse on an early or missing frame sync
//
// Optional feature (macro TDM_DEMUX_PARITY_EN):
//   din_par     odd-parity bit covering din
//   par_err     one-cycle pulse when an accepted sample fails parity. The
//               frame that contains it is then withheld from dout.
// ============================================================================
module tdm_demux #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  input  logic                  frame_sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic                  din_par,
  output logic                  par_err,
`endif
  output logic [CH*WIDTH-1:0]   dout,
  output logic                  dout_valid,
  output logic [SW-1:0]         slot,
  output logic                  locked,
  output logic                  frame_err
);

  // The slot value that marks the final channel of a frame.
  localparam logic [SW-1:0] LAST_SLOT = SW'(CH - 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t state;

  // Channel CH-1 never needs a shadow register. It is taken straight from
  // din on the completing edge.
  logic [WIDTH-1:0] shadow [CH-1];

  // Classification of the sample on the bus this cycle.
  logic take_sync;
  logic early_sync;
  logic missing_sync;
  logic normal_sample;
  logic last_sample;
  logic sample_bad;
  logic frame_ok;

`ifdef TDM_DEMUX_PARITY_EN
  // This bit is set once any accepted sample of the frame in progress has
  // failed parity.
  logic frame_bad;
`endif

  // Decode what the current sample means for the framer. A synced sample
  // always starts a new frame, both while hunting and while locked. When it
  // arrives mid-frame, it also flags an early sync. Once locked, an unsynced
  // sample at slot 0 means the stream has lost alignment.
  always_comb begin
    take_sync     = din_valid && frame_sync;
    early_sync    = din_valid && frame_sync && (state == LOCK) && (slot != '0);
    missing_sync  = din_valid && !frame_sync && (state == LOCK) && (slot == '0);
    normal_sample = din_valid && !frame_sync && (state == LOCK) && (slot != '0);
    last_sample   = normal_sample && (slot == LAST_SLOT);
`ifdef TDM_DEMUX_PARITY_EN
    // Parity is odd over {din_par, din}. An even XOR result is a failure.
    // Only accepted samples are checked, so a dropped sample never raises
    // par_err.
    sample_bad    = (take_sync || normal_sample) && !(^{din_par, din});
    frame_ok      = !(frame_bad || sample_bad);
`else
    sample_bad    = 1'b0;
    frame_ok      = 1'b1;
`endif
  end

  // Main framer. It holds the FSM, the slot counter, the shadow registers and
  // every registered output. The pulse outputs default to low and are raised
  // only on the edge that detects their event. This keeps them to exactly
  // one cycle. frame_err and dout_valid come from mutually exclusive sample
  // classes, so they can never be high together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= '0;
      locked     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      for (int k = 0; k < CH - 1; k++) begin
        shadow[k] <= '0;
      end
`ifdef TDM_DEMUX_PARITY_EN
      par_err    <= 1'b0;
      frame_bad  <= 1'b0;
`endif
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err    <= sample_bad;
`endif

      if (take_sync) begin
        // A synced sample starts a fresh frame, whatever the state. Any
        // partial frame is abandoned. Its shadows are simply overwritten
        // later and are never exposed, because dout only loads on a
        // completed frame.
        state     <= LOCK;
        locked    <= 1'b1;
        shadow[0] <= din;
        slot      <= SW'(1);
        frame_err <= early_sync;
`ifdef TDM_DEMUX_PARITY_EN
        frame_bad <= sample_bad;
`endif
      end else if (missing_sync) begin
        // Alignment is lost. Drop the sample and go back to hunting for a
        // sync marker.
        state     <= HUNT;
        locked    <= 1'b0;
        frame_err <= 1'b1;
      end else if (last_sample) begin
        // The final channel completes the frame. The stored channels plus
        // the live sample are published together, so dout is always one
        // coherent frame. A frame marked bad by parity still wraps the slot
        // counter, but it is not published.
        if (frame_ok) begin
          for (int k = 0; k < CH - 1; k++) begin
            dout[k*WIDTH +: WIDTH] <= shadow[k];
          end
          dout[(CH-1)*WIDTH +: WIDTH] <= din;
          dout_valid <= 1'b1;
        end
        slot <= '0;
`ifdef TDM_DEMUX_PARITY_EN
        frame_bad <= 1'b0;
`endif
      end else if (normal_sample) begin
        // This is a middle channel of the frame. Park it in its shadow
        // register and move to the next slot. Slot 0 cannot appear here,
        // because that case is a missing sync.
        for (int k = 1; k < CH - 1; k++) begin
          if (slot == SW'(k)) begin
            shadow[k] <= din;
          end
        end
        slot <= slot + SW'(1);
`ifdef TDM_DEMUX_PARITY_EN
        if (sample_bad) begin
          frame_bad <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// ============================================================================
// tb_tdm_demux
// ----------------------------------------------------------------------------
// Directed testbench for tdm_demux. A queue-based frame model predicts every
// output. A negedge compare process checks the DUT against the model on every
// cycle. Hand-computed literal checks at key points pin the model itself.
// ============================================================================
module tb_tdm_demux;

  localparam int WIDTH = 8;
  localparam int CH    = 4;
  localparam int SW    = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [WIDTH-1:0]     din = '0;
  logic                 din_valid = 1'b0;
  logic                 frame_sync = 1'b0;
  logic [CH*WIDTH-1:0]  dout;
  logic                 dout_valid;
  logic [SW-1:0]        slot;
  logic                 locked;
  logic                 frame_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic                 din_par = 1'b1;
  logic                 par_err;
  logic                 corrupt = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  tdm_demux #(.WIDTH(WIDTH), .CH(CH), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
`ifdef TDM_DEMUX_PARITY_EN
    .din_par    (din_par),
    .par_err    (par_err),
`endif
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Reference model. A frame is built up as a queue of accepted samples.
  // The expected slot is the queue length. A frame is published when the
  // queue reaches CH entries, unless parity has marked it bad.
  logic [WIDTH-1:0]    m_q [$];
  logic                m_locked = 1'b0;
  logic [CH*WIDTH-1:0] m_dout   = '0;
  logic                m_valid  = 1'b0;
  logic                m_err    = 1'b0;
  logic                m_bad    = 1'b0;
  logic                m_perr   = 1'b0;
  logic                par_ok;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_locked = 1'b0;
      m_dout   = '0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      m_bad    = 1'b0;
      m_perr   = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_perr  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_ok = ^{din_par, din};
`else
      par_ok = 1'b1;
`endif
      if (din_valid) begin
        if (frame_sync) begin
          if (m_locked && m_q.size() != 0) m_err = 1'b1;
          m_locked = 1'b1;
          m_q.delete();
          m_q.push_back(din);
          m_bad  = !par_ok;
          m_perr = !par_ok;
        end else if (m_locked) begin
          if (m_q.size() == 0) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
          end else begin
            m_q.push_back(din);
            if (!par_ok) begin
              m_bad  = 1'b1;
              m_perr = 1'b1;
            end
            if (m_q.size() == CH) begin
              if (!m_bad) begin
                for (int k = 0; k < CH; k++) m_dout[k*WIDTH +: WIDTH] = m_q[k];
                m_valid = 1'b1;
              end
              m_q.delete();
              m_bad = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare the DUT with the model on every falling edge, away from the
  // active edge.
  always @(negedge clk) begin
    checkOutput("dout",       64'(dout),       64'(m_dout));
    checkOutput("dout_valid", 64'(dout_valid), 64'(m_valid));
    checkOutput("slot",       64'(slot),       64'(m_q.size()));
    checkOutput("locked",     64'(locked),     64'(m_locked));
    checkOutput("frame_err",  64'(frame_err),  64'(m_err));
    checkOutput("err_and_valid", 64'(frame_err && dout_valid), 64'(0));
`ifdef TDM_DEMUX_PARITY_EN
    checkOutput("par_err",    64'(par_err),    64'(m_perr));
`endif
  end

  // Drive one cycle of bus activity. The new value is applied just after a
  // rising edge, so the next rising edge samples it.
  task automatic applyStimulus(input logic v, input logic s, input logic [WIDTH-1:0] d);
    @(posedge clk);
    #1;
    din_valid  = v;
    frame_sync = s;
    din        = d;
`ifdef TDM_DEMUX_PARITY_EN
    din_par    = corrupt ? (^d) : ~(^d);
`endif
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    $display("[TB] tdm_demux directed test start");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_dout",   64'(dout),   64'h0);
    checkOutput("reset_slot",   64'(slot),   64'h0);
    checkOutput("reset_locked", 64'(locked), 64'h0);
    rst = 1'b0;

    // First frame, sent in order.
    applyStimulus(1, 1, 8'h11);
    applyStimulus(1, 0, 8'h22);
    applyStimulus(1, 0, 8'h33);
    applyStimulus(1, 0, 8'h44);
    applyStimulus(0, 0, 8'h00);
    checkOutput("frame1_dout",  64'(dout),       64'h44332211);
    checkOutput("frame1_valid", 64'(dout_valid), 64'h1);
    checkOutput("frame1_slot",  64'(slot),       64'h0);
    checkOutput("frame1_lock",  64'(locked),     64'h1);
    applyStimulus(0, 0, 8'h00);
    checkOutput("frame1_pulse_end", 64'(dout_valid), 64'h0);

    // Sync hunt from a fresh reset.
    pulseReset();
    applyStimulus(1, 0, 8'hAA);
    applyStimulus(1, 0, 8'hBB);
    applyStimulus(1, 1, 8'h01);
    checkOutput("hunt_unlocked", 64'(locked), 64'h0);
    applyStimulus(1, 0, 8'h02);
    checkOutput("hunt_locked",   64'(locked), 64'h1);
    applyStimulus(1, 0, 8'h03);
    applyStimulus(1, 0, 8'h04);
    applyStimulus(0, 0, 8'h00);
    checkOutput("hunt_dout", 64'(dout), 64'h04030201);

    // Early sync while locked.
    applyStimulus(1, 1, 8'h10);
    applyStimulus(1, 0, 8'h20);
    applyStimulus(1, 1, 8'h30);
    applyStimulus(1, 0, 8'h40);
    checkOutput("early_err",  64'(frame_err), 64'h1);
    checkOutput("early_hold", 64'(dout),      64'h04030201);
    applyStimulus(1, 0, 8'h50);
    applyStimulus(1, 0, 8'h60);
    applyStimulus(0, 0, 8'h00);
    checkOutput("early_dout", 64'(dout), 64'h60504030);

    // Missing sync after a completed frame.
    applyStimulus(1, 0, 8'h77);
    applyStimulus(0, 0, 8'h00);
    checkOutput("miss_err",    64'(frame_err), 64'h1);
    checkOutput("miss_locked", 64'(locked),    64'h0);
    checkOutput("miss_dout",   64'(dout),      64'h60504030);

    // Gaps between samples, then a reset in the middle of the frame.
    applyStimulus(1, 1, 8'hA1);
    repeat (3) applyStimulus(0, 0, 8'h00);
    applyStimulus(1, 0, 8'hB2);
    applyStimulus(0, 0, 8'h00);
    checkOutput("gap_slot", 64'(slot), 64'h2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_dout",   64'(dout),   64'h0);
    checkOutput("midreset_slot",   64'(slot),   64'h0);
    checkOutput("midreset_locked", 64'(locked), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) applyStimulus(0, 0, 8'h00);

    // An unsynced sample after reset is dropped. It is followed by two
    // back-to-back frames.
    applyStimulus(1, 0, 8'hC3);
    applyStimulus(1, 1, 8'h01);
    applyStimulus(1, 0, 8'h02);
    applyStimulus(1, 0, 8'h03);
    applyStimulus(1, 0, 8'h04);
    applyStimulus(1, 1, 8'h05);
    checkOutput("b2b_first", 64'(dout), 64'h04030201);
    applyStimulus(1, 0, 8'h06);
    applyStimulus(1, 0, 8'h07);
    applyStimulus(1, 0, 8'h08);
    applyStimulus(0, 0, 8'h00);
    checkOutput("b2b_second", 64'(dout), 64'h08070605);

`ifdef TDM_DEMUX_PARITY_EN
    // One sample carries bad parity, so the frame is withheld. The next
    // clean frame then loads normally.
    applyStimulus(1, 1, 8'h21);
    corrupt = 1'b1;
    applyStimulus(1, 0, 8'h22);
    corrupt = 1'b0;
    applyStimulus(1, 0, 8'h23);
    checkOutput("par_err_pulse", 64'(par_err), 64'h1);
    applyStimulus(1, 0, 8'h24);
    applyStimulus(1, 1, 8'h31);
    checkOutput("par_hold", 64'(dout), 64'h08070605);
    applyStimulus(1, 0, 8'h32);
    applyStimulus(1, 0, 8'h33);
    applyStimulus(1, 0, 8'h34);
    applyStimulus(0, 0, 8'h00);
    checkOutput("par_clean", 64'(dout), 64'h34333231);
`endif

    repeat (2) applyStimulus(0, 0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of the team's 2:1/N:1 mux datapath. It takes a serial stream of samples that an upstream mux time-slices over one shared bus and routes each sample to its own channel register. A frame-sync marker identifies channel 0. The block presents a complete, coherent frame on a flat parallel output bus with a one-cycle valid pulse. It sits between the shared bus and the per-channel consumers.

## Interface
- `WIDTH`, default 8: sample width in bits.
- `CH`, default 4: channels per frame; legal range 2..16.
- `SW`, default 2: slot counter width; must equal ceil(log2(CH)).

Ports:
- `clk`  in  1  clock; all logic updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  WIDTH  sample currently on the shared bus.
- `din_valid`  in  1  `din` holds a sample this cycle.
- `frame_sync`  in  1  qualifies the current valid sample as channel 0; ignored when `din_valid`=0.
- `dout`  out  CH*WIDTH  last complete frame; channel k occupies bits [k*WIDTH +: WIDTH].
- `dout_valid`  out  1  one-cycle pulse: `dout` was updated on the previous edge.
- `slot`  out  SW  index of the channel the next accepted sample will fill.
- `locked`  out  1  1 while in state LOCK.
- `frame_err`  out  1  one-cycle pulse on any framing violation.

## Operation
- Internal state: FSM state, `slot` counter, shadow registers for channels 0..CH-2.
- FSM states:
  - HUNT (reset state): every sample without `frame_sync` is dropped.
  - LOCK.
- HUNT -> LOCK: on `din_valid` && `frame_sync`. That sample goes to shadow[0] and `slot` becomes 1.
- Normal sample in LOCK: on `din_valid` && !`frame_sync` && `slot`!=0, the sample goes to shadow[`slot`].
  - If `slot`<CH-1: `slot` increments.
  - If `slot`==CH-1: on the same edge, `dout` loads shadow[0..CH-2] plus `din` as channel CH-1. `slot` wraps to 0 and `dout_valid` goes high for the next cycle.
- Early sync in LOCK: on `din_valid` && `frame_sync` && `slot`!=0:
  - `frame_err` pulses and the partial frame is discarded; `dout` is unchanged.
  - The sample is taken as the new channel 0 and `slot` becomes 1. The block stays in LOCK.
- Correct sync in LOCK: on `din_valid` && `frame_sync` && `slot`==0, this is the normal start of the next frame.
- Missing sync in LOCK: on `din_valid` && !`frame_sync` && `slot`==0, `frame_err` pulses, the sample is dropped, and the FSM returns to HUNT.
- When `din_valid`=0, nothing changes; gaps between samples of any length are legal.
- Shadow registers are never cleared except by reset. Stale shadow contents are never visible, because `dout` only loads after a full frame has been accepted in sequence.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `slot`=0, `locked`=0, `frame_err`=0, FSM=HUNT, shadows=0.
- Latency: the last sample of a frame is accepted on edge N. `dout` and `dout_valid`=1 are visible after edge N. `dout_valid` is low again after edge N+1 unless another frame completes.
- Back-to-back frames with no idle cycles give `dout_valid` high once every CH cycles.
- `frame_err`, `locked` and `slot` are registered outputs, updated on the edge that accepts or rejects the sample.
- `frame_err` and `dout_valid` are never high in the same cycle.
- Reset mid-frame: all state clears immediately and asynchronously. The first frame after reset requires a fresh `frame_sync`.

## Configuration
- Macro: `TDM_DEMUX_PARITY_EN`.
- Defined:
  - Adds input `din_par` (1 bit) and output `par_err` (1 bit, reset 0).
  - Each accepted sample is checked for odd parity over {`din_par`,`din`}.
  - On a mismatch, `par_err` pulses for one cycle and the whole current frame is marked bad.
  - At frame completion, a bad frame does not load `dout` and `dout_valid` stays 0. `slot` wraps normally and the FSM stays in LOCK.
  - The bad mark clears at the start of the next frame.
- Undefined: neither port exists and no parity check is performed.

## Test plan
- Frame in order: after reset, send `din_valid`=1 with samples 0x11 (`frame_sync`=1), 0x22, 0x33, 0x44 on consecutive cycles. Required: `dout`=0x44332211 one cycle after the 0x44 edge, `dout_valid` high for exactly one cycle, `slot`=0, `locked`=1.
- Sync hunt: send 0xAA and 0xBB without sync, then 0x01 with sync, then 0x02, 0x03, 0x04. Required: `locked`=0 until the 0x01 edge, `dout`=0x04030201, no `frame_err`.
- Early sync: in LOCK, send 0x10(sync), 0x20, then 0x30(sync), 0x40, 0x50, 0x60. Required: `frame_err` pulses on the 0x30 edge and `dout`=0x60504030.
- Missing sync: after a completed frame, send 0x77 without sync. Required: `frame_err` pulse, `locked`=0, `dout` unchanged.
- Gaps and reset: insert 3 idle cycles between each sample of a frame, then assert `rst` after the second sample. Required: outputs are 0 immediately and no `dout_valid` pulse occurs.
- Parity (`TDM_DEMUX_PARITY_EN` defined): one sample of a frame carries bad parity. Required: `par_err` pulses, `dout` is not updated, and the next clean frame loads normally.
